// File: rtl/int_root_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_root_pkg : shared FSM state, mode encodings and root-width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package int_root_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    CU   = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  function automatic int sqrt_bits(input int width);
    return (width + 1) / 2;
  endfunction

  function automatic int cbrt_bits(input int width);
    return (width + 2) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_root_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_root_mul : unsigned multiplier with a registered, full-width product
// Rev 1.0
// ----------------------------------------------------------------------------
module int_root_mul #(
  parameter int AW = 32,
  parameter int BW = 16
) (
  input  logic               clk,
  input  logic [AW-1:0]      a,
  input  logic [BW-1:0]      b,
  output logic [AW+BW-1:0]   p
);

  logic [AW+BW-1:0] p_d;
  logic [AW+BW-1:0] p_q;

  always_comb begin
    p_d = (AW+BW)'(a) * (AW+BW)'(b);
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p = p_q;

endmodule
`default_nettype wire

// File: rtl/int_root_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_root_unit : bit-serial floor square/cube root with remainder
// Rev 1.0
// ----------------------------------------------------------------------------
module int_root_unit
  import int_root_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int RS    = sqrt_bits(WIDTH),
  localparam int RC    = cbrt_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RS-1:0]    root,
  output logic [WIDTH-1:0] rem,
  output logic             busy
);

  localparam int IW = $clog2(RS);
  localparam int PW = 3 * RS;
  localparam logic [RS-1:0] ONE = RS'(1);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RS-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] keep_q, keep_d;
  logic [RS-1:0]    root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [RS-1:0]    cand;
  logic [2*RS-1:0]  mul_a;
  logic [PW-1:0]    prod;
  logic             fits;

  assign cand = acc_q | (ONE << idx_q);
  assign fits = (prod <= PW'(num_q));

  // CU multiplies the held square by cand again; every other state squares cand
  always_comb begin
    mul_a = {{RS{1'b0}}, cand};
    if (state_q == CU) mul_a = prod[2*RS-1:0];
  end

  int_root_mul #(
    .AW (2 * RS),
    .BW (RS)
  ) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (cand),
    .p   (prod)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    num_d       = num_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    keep_d      = keep_q;
    root_d      = root_q;
    rem_d       = rem_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          num_d      = num;
          mode_d     = mode;
          acc_d      = '0;
          keep_d     = '0;
          idx_d      = (mode == MODE_CBRT) ? IW'(RC - 1) : IW'(RS - 1);
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = SQ;
        end
      end
      SQ: begin
        state_d = (mode_q == MODE_CBRT) ? CU : CMP;
      end
      CU: begin
        state_d = CMP;
      end
      CMP: begin
        // keep_q always holds acc^k, so the remainder never needs a re-multiply
        if (fits) begin
          acc_d  = cand;
          keep_d = prod[WIDTH-1:0];
        end
        if (idx_q == '0) begin
          root_d  = fits ? cand : acc_q;
          rem_d   = num_q - (fits ? prod[WIDTH-1:0] : keep_q);
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = SQ;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      num_q       <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      keep_q      <= '0;
      root_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign root      = root_q;
  assign rem       = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_int_root_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_int_root_unit : directed and random scoreboard bench for int_root_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_int_root_unit;

  localparam int WIDTH = 32;
  localparam int RS    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] num = '0;
  logic             mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [RS-1:0]    root;
  logic [WIDTH-1:0] rem;
  logic             busy;

  always #5 clk = ~clk;

  int_root_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .busy      (busy)
  );

  typedef struct {
    logic             m;
    logic [WIDTH-1:0] n;
    logic [RS-1:0]    r;
    logic [WIDTH-1:0] rm;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint unsigned ipow(input longint unsigned r, input int k);
    return (k == 3) ? r * r * r : r * r;
  endfunction

  // Reference: floating-point estimate corrected by exact integer search
  task automatic ref_root(input logic m, input logic [WIDTH-1:0] n,
                          output logic [RS-1:0] r, output logic [WIDTH-1:0] rm);
    int k;
    longint unsigned x;
    longint unsigned nn;
    k  = m ? 3 : 2;
    nn = longint'(n);
    x  = longint'($rtoi($pow(real'(nn), 1.0 / k)));
    while (x > 0 && ipow(x, k) > nn) x--;
    while (ipow(x + 1, k) <= nn) x++;
    r  = x[RS-1:0];
    rm = WIDTH'(nn - ipow(x, k));
  endtask

  task automatic start_job(input logic m, input logic [WIDTH-1:0] n, input bit use_ref,
                           input logic [RS-1:0] er, input logic [WIDTH-1:0] erm);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    e.m = m;
    e.n = n;
    if (use_ref) ref_root(m, n, e.r, e.rm);
    else begin
      e.r  = er;
      e.rm = erm;
    end
    e.lat = m ? 34 : 33;
    sb.push_back(e);
    in_valid = 1'b1;
    mode     = m;
    num      = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
    num      = $urandom;
    mode     = 1'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic finish_job(input int hold);
    exp_t e;
    int   cyc;
    logic [RS-1:0]    r_seen;
    logic [WIDTH-1:0] rm_seen;
    out_ready = (hold == 0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("latency", cyc, e.lat);
    check("root", root, e.r);
    check("rem", rem, e.rm);
    check("busy_at_done", busy, 0);
    r_seen  = root;
    rm_seen = rem;
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      num      = $urandom;
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_root", root, r_seen);
      check("hold_rem", rem, rm_seen);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_out_valid", out_valid, 0);
    check("handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw_valid;
    logic             m;
    logic [WIDTH-1:0] n;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_root", root, 0);
    check("reset_rem", rem, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    start_job(1'b1, 32'd27, 1'b0, 16'd3, 32'd0);               finish_job(0);
    start_job(1'b1, 32'd26, 1'b0, 16'd2, 32'd18);              finish_job(0);
    start_job(1'b1, 32'hFFFF_FFFF, 1'b0, 16'd1625, 32'd3951670); finish_job(0);
    start_job(1'b0, 32'd1000000, 1'b0, 16'd1000, 32'd0);       finish_job(0);
    start_job(1'b0, 32'hFFFF_FFFF, 1'b0, 16'd65535, 32'd131070); finish_job(0);
    start_job(1'b0, 32'd0, 1'b0, 16'd0, 32'd0);                finish_job(0);
    start_job(1'b1, 32'd0, 1'b0, 16'd0, 32'd0);                finish_job(0);

    // Backpressure with ignored in_valid pulses, then confirm no queued job
    start_job(1'b0, 32'd50, 1'b0, 16'd7, 32'd1);
    finish_job(20);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_valid |= out_valid | busy;
    end
    check("no_queued_job", saw_valid, 0);

    // Abort a cube job with a one-cycle reset at cycle 10
    start_job(1'b1, 32'd64, 1'b0, 16'd4, 32'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    check("abort_no_result", saw_valid, 0);
    start_job(1'b0, 32'd81, 1'b0, 16'd9, 32'd0);
    finish_job(0);

    // Exact-power boundaries checked against the reference model
    start_job(1'b1, 32'd4291015625, 1'b1, '0, '0); finish_job(0);
    start_job(1'b1, 32'd4291015624, 1'b1, '0, '0); finish_job(0);
    start_job(1'b0, 32'hFFFE_0001, 1'b1, '0, '0);  finish_job(0);
    start_job(1'b0, 32'hFFFE_0000, 1'b1, '0, '0);  finish_job(0);
    start_job(1'b1, 32'd1, 1'b1, '0, '0);          finish_job(0);

    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom);
      case (i % 3)
        0:       n = $urandom;
        1:       n = $urandom_range(0, 5000);
        default: n = $urandom >> $urandom_range(0, 31);
      endcase
      start_job(m, n, 1'b1, '0, '0);
      finish_job((i % 17 == 0) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_root_unit.md
Name: int_root_unit

Overview:
Parametrised integer root engine; successor of the fixed 32-bit cube-root calculator.
Computes floor square root or floor cube root (runtime mode) of an unsigned WIDTH-bit operand, plus remainder.
Bit-serial digit search, one multiplier reused across cycles, valid/ready handshakes on both sides.
Sits between the operand-capture logic and result display/consumer logic.

Parameters:
WIDTH, 32, operand width in bits (>= 4)
RS, (WIDTH+1)/2, square-root result bits (derived, not overridable)
RC, (WIDTH+2)/3, cube-root result bits (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand/mode valid
in_ready  output  1  engine idle, will accept
num  input  WIDTH  unsigned operand, sampled on accept
mode  input  1  0 = square root, 1 = cube root, sampled on accept
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
root  output  RS  floor root, zero-extended in cube mode
rem  output  WIDTH  num - root^k (k = 2 or 3)
busy  output  1  high from accept until out_valid

Behaviour:
- Reset: clk and rst_n as named; reset is synchronous and active-low. While rst_n=0 at an edge: state IDLE, in_ready=0, out_valid=0, busy=0, root=0, rem=0; operand/mode/bit-index regs cleared. in_ready goes to 1 on the first edge with rst_n=1.
- States: IDLE, SQ, CU, CMP, DONE.
- IDLE: in_ready=1. Accept = in_valid & in_ready at an edge; latch num, mode; acc=0; bit index i = RS-1 (square) or RC-1 (cube); go to SQ; busy=1, in_ready=0.
- SQ: cand = acc | (1<<i); prod = cand*cand (full 2*RS bits, no truncation). Next: CU if cube, else CMP.
- CU: prod = prod*cand (3*RC bits min, compute in 3*RS to avoid overflow). Next CMP.
- CMP: if prod <= num (widened compare) acc = cand. If i==0 go DONE, capture root=acc, rem = num - acc^k (from held final prod when bit kept, else computed with the single multiplier path; must be exact); else i=i-1, go SQ.
- Latency (accept edge to edge where out_valid rises): square 2*RS+1, cube 3*RC+1. WIDTH=32: square 33, cube 34.
- DONE: out_valid=1, busy=0; root/rem stable. On out_valid & out_ready at an edge: out_valid=0, go IDLE (in_ready=1 next cycle; no same-cycle re-accept).
- out_ready low: hold indefinitely, outputs unchanged.
- in_valid while busy/DONE: ignored, not queued.
- num changes after accept: no effect.
- rst_n low mid-computation or in DONE: abort, return to reset values next edge, result discarded.
- num=0: root=0, rem=0 with normal latency. Max operand must not overflow any intermediate.

Decomposition:
- Shared package int_root_pkg: state enum (IDLE, SQ, CU, CMP, DONE), MODE_SQRT=0 / MODE_CBRT=1 constants, width helper functions for RS/RC.
- One sub-module natural: int_root_mul (registered-output unsigned multiplier, used by SQ/CU); keeps the multiplier swappable for a pipelined version later. FSM and datapath remain in int_root_unit.

Test Plan:
- Reset then mode=1, num=27, out_ready=1 -> out_valid exactly 34 cycles after accept, root=3, rem=0; in_ready back next cycle.
- mode=1, num=26 -> root=2, rem=18; mode=1, num=32'hFFFFFFFF -> root=1625, rem=3951670.
- mode=0, num=1000000 -> root=1000, rem=0 after 33 cycles; mode=0, num=32'hFFFFFFFF -> root=65535, rem=131070; num=0 either mode -> root=0, rem=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_valid pulses ignored, in_ready=0; raise out_ready -> one-cycle handshake, IDLE.
- Reset mid-op: rst_n=0 for 1 cycle at cycle 10 of cube(64) -> out_valid never rises for that job; new square(81) -> root=9, rem=0.
- Random sweep 10k operands both modes, WIDTH=32 and WIDTH=12 -> root^k <= num < (root+1)^k, rem exact, latency exact.
